// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract built from STAGES ripple segments with a registered
// carry between segments. The whole pipe advances together under a single valid/ready enable.

module pipelined_addsub_seg #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout,
  output logic             OVF
);
  localparam int SEG = WIDTH / STAGES;

  logic              adv;
  logic [STAGES:1]   vld_pipe;
  logic              ovf_q;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // x_q holds unconsumed A segments in its low end and finished sum segments
  // rotated in at the top, so after STAGES steps it is the aligned result.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int BW = WIDTH - k * SEG;

    logic [WIDTH-1:0] x_in, x_nx, x_q;
    logic [BW-1:0]    b_in;
    logic             c_in, c_q, co;
    logic [SEG-1:0]   s;

    if (k == 0) begin : g_first
      assign x_in = A;
      assign b_in = B ^ {WIDTH{SUB}};
      assign c_in = Cin ^ SUB;
    end else begin : g_next
      assign x_in = g_stg[k-1].x_q;
      assign b_in = g_stg[k-1].g_fwd.b_q;
      assign c_in = g_stg[k-1].c_q;
    end

    pipelined_addsub_seg #(.W(SEG)) u_seg (
      .a  (x_in[SEG-1:0]),
      .b  (b_in[SEG-1:0]),
      .ci (c_in),
      .s  (s),
      .co (co)
    );

    if (STAGES == 1) begin : g_one
      assign x_nx = s;
    end else begin : g_rot
      assign x_nx = {s, x_in[WIDTH-1:SEG]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        x_q <= x_nx;
        c_q <= co;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [BW-SEG-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   b_q <= '0;
        else if (adv) b_q <= b_in[BW-1:SEG];
      end
    end

    if (k == STAGES - 1) begin : g_last
      // carry into the MSB recovered from the MSB sum bit and its operand bits
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= co ^ (s[SEG-1] ^ x_in[SEG-1] ^ b_in[SEG-1]);
      end
    end
  end

  assign SUM  = g_stg[STAGES-1].x_q;
  assign Cout = g_stg[STAGES-1].c_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: scoreboard on the 32/2 instance plus a sweep over
// (8,1), (16,4), (64,8) instances checking results and latency.

module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          tag;
  } exp_t;

  exp_t q_main[$], q8[$], q16[$], q64[$];
  exp_t mon_e;

  // main 32-bit, 2-stage instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  pipelined_addsub #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .SUB(sub), .out_valid(out_valid), .out_ready(out_ready),
    .SUM(sum), .Cout(cout), .OVF(ovf));

  // sweep instances share stimulus
  logic        sw_valid, sw_cin, sw_sub, sw_ordy;
  logic [63:0] sw_a, sw_b;
  logic        rdy8, rdy16, rdy64, ov8, ov16, ov64, co8, co16, co64, of8, of16, of64;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [63:0] s64;

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy8),
    .A(sw_a[7:0]), .B(sw_b[7:0]), .Cin(sw_cin), .SUB(sw_sub), .out_valid(ov8),
    .out_ready(sw_ordy), .SUM(s8), .Cout(co8), .OVF(of8));

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy16),
    .A(sw_a[15:0]), .B(sw_b[15:0]), .Cin(sw_cin), .SUB(sw_sub), .out_valid(ov16),
    .out_ready(sw_ordy), .SUM(s16), .Cout(co16), .OVF(of16));

  pipelined_addsub #(.WIDTH(64), .STAGES(8)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy64),
    .A(sw_a), .B(sw_b), .Cin(sw_cin), .SUB(sw_sub), .out_valid(ov64),
    .out_ready(sw_ordy), .SUM(s64), .Cout(co64), .OVF(of64));

  function automatic exp_t mk(logic [63:0] s_, logic c_, logic o_);
    exp_t e;
    e.sum = s_; e.cout = c_; e.ovf = o_; e.tag = 0;
    return e;
  endfunction

  // reference: full-width arithmetic, overflow from operand/result sign bits
  function automatic exp_t model(int w, logic [63:0] a_, logic [63:0] b_, logic c_, logic s_);
    logic [63:0] mask, ax, bx, sm;
    logic [64:0] full;
    exp_t e;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    ax   = a_ & mask;
    bx   = (s_ ? ~b_ : b_) & mask;
    full = {1'b0, ax} + {1'b0, bx} + {64'd0, c_ ^ s_};
    sm   = full[63:0] & mask;
    e.sum  = sm;
    e.cout = full[w];
    e.ovf  = (ax[w-1] == bx[w-1]) && (sm[w-1] != ax[w-1]);
    e.tag  = 0;
    return e;
  endfunction

  // scoreboard for the main instance
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_tests++;
      if (q_main.size() == 0) begin
        n_fail++;
        $display("FAIL main_unexpected: out_valid with sum=%h but nothing pending", sum);
      end else begin
        mon_e = q_main.pop_front();
        if ({sum, cout, ovf} !== {mon_e.sum[31:0], mon_e.cout, mon_e.ovf}) begin
          n_fail++;
          $display("FAIL main_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, mon_e.sum[31:0], mon_e.cout, mon_e.ovf);
        end
      end
    end
  end

  // call aligned to posedge+1; returns at posedge+1 after the transfer
  task automatic send(input logic [31:0] a_, input logic [31:0] b_, input logic c_,
                      input logic s_, input exp_t e);
    int n = 0;
    in_valid = 1'b1; a = a_; b = b_; cin = c_; sub = s_;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %b, want 1", in_ready);
    end else q_main.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_check(input string name);
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (q_main.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results missing, want 0", name, q_main.size());
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; sw_ordy = 1'b1; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b sum=%h c=%b o=%b rdy=%b, want 0 0 0 0 1",
               out_valid, sum, cout, ovf, in_ready);
    end
    n_tests++;
    if ({ov8, ov16, ov64, s8, s16, s64} !== '0) begin
      n_fail++;
      $display("FAIL reset_sweep: got v=%b%b%b, want outputs all 0", ov8, ov16, ov64);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, mk(64'h00010000, 1'b0, 1'b0));
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_lat1: out_valid=%b, want 0", out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_lat2: out_valid=%b, want 1", out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_single: out_valid=%b, want 0", out_valid);
    end
    @(posedge clk); #1;
    drain_check("basic");
  endtask

  task automatic test_sub();
    send(32'd5, 32'd7, 1'b1, 1'b1, mk(64'hFFFFFFFD, 1'b0, 1'b0));
    send(32'd7, 32'd5, 1'b0, 1'b1, mk(64'h2, 1'b1, 1'b0));
    drain_check("sub");
  endtask

  task automatic test_ovf();
    send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, mk(64'h80000000, 1'b0, 1'b1));
    send(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, mk(64'h0, 1'b1, 1'b0));
    send(32'h80000000, 32'h1, 1'b0, 1'b1, mk(64'h7FFFFFFF, 1'b1, 1'b1));
    drain_check("ovf");
  endtask

  task automatic test_back_to_back_stall();
    logic [34:0] snap;
    fork
      begin
        logic [31:0] ra, rb;
        logic        rc, rs;
        for (int i = 0; i < 8; i++) begin
          ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
          send(ra, rb, rc, rs, model(32, {32'd0, ra}, {32'd0, rb}, rc, rs));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        snap = {out_valid, sum, cout, ovf};
        n_tests++;
        if ({in_ready, out_valid} !== 2'b01) begin
          n_fail++;
          $display("FAIL stall_ready: in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid);
        end
        repeat (2) begin
          @(negedge clk);
          n_tests++;
          if ({out_valid, sum, cout, ovf} !== snap || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: got %h rdy=%b, want %h rdy=0",
                     {out_valid, sum, cout, ovf}, in_ready, snap);
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain_check("stream");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h12340000; b = 32'h00005678; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    a = 32'hDEADBEEF; b = 32'h11111111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_inflight: out_valid=%b, want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_clear: got v=%b sum=%h c=%b o=%b rdy=%b, want 0 0 0 0 1",
               out_valid, sum, cout, ovf, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    q_main.delete();
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rmid_stale: out_valid=%b sum=%h, want 0", out_valid, sum);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    exp_t e;
    localparam int N = 40;
    for (int i = 0; i < N + 12; i++) begin
      @(posedge clk); #1;
      if (i < N) begin
        sw_valid = 1'b1;
        sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
        if (i % 10 == 3) sw_b = {64{1'b1}};
        sw_cin = 1'($urandom); sw_sub = 1'($urandom);
        e = model(8,  sw_a, sw_b, sw_cin, sw_sub); e.tag = i; q8.push_back(e);
        e = model(16, sw_a, sw_b, sw_cin, sw_sub); e.tag = i; q16.push_back(e);
        e = model(64, sw_a, sw_b, sw_cin, sw_sub); e.tag = i; q64.push_back(e);
      end else sw_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({rdy8, rdy16, rdy64} !== 3'b111) begin
        n_fail++; $display("FAIL sweep_ready: got %b%b%b, want 111", rdy8, rdy16, rdy64);
      end
      if (ov8) begin
        n_tests++;
        if (q8.size() == 0) begin
          n_fail++; $display("FAIL sweep8_unexpected: sum=%h with nothing pending", s8);
        end else begin
          e = q8.pop_front();
          if ({s8, co8, of8} !== {e.sum[7:0], e.cout, e.ovf} || i - e.tag != 1) begin
            n_fail++;
            $display("FAIL sweep8: got sum=%h c=%b o=%b lat=%0d, want sum=%h c=%b o=%b lat=1",
                     s8, co8, of8, i - e.tag, e.sum[7:0], e.cout, e.ovf);
          end
        end
      end
      if (ov16) begin
        n_tests++;
        if (q16.size() == 0) begin
          n_fail++; $display("FAIL sweep16_unexpected: sum=%h with nothing pending", s16);
        end else begin
          e = q16.pop_front();
          if ({s16, co16, of16} !== {e.sum[15:0], e.cout, e.ovf} || i - e.tag != 4) begin
            n_fail++;
            $display("FAIL sweep16: got sum=%h c=%b o=%b lat=%0d, want sum=%h c=%b o=%b lat=4",
                     s16, co16, of16, i - e.tag, e.sum[15:0], e.cout, e.ovf);
          end
        end
      end
      if (ov64) begin
        n_tests++;
        if (q64.size() == 0) begin
          n_fail++; $display("FAIL sweep64_unexpected: sum=%h with nothing pending", s64);
        end else begin
          e = q64.pop_front();
          if ({s64, co64, of64} !== {e.sum, e.cout, e.ovf} || i - e.tag != 8) begin
            n_fail++;
            $display("FAIL sweep64: got sum=%h c=%b o=%b lat=%0d, want sum=%h c=%b o=%b lat=8",
                     s64, co64, of64, i - e.tag, e.sum, e.cout, e.ovf);
          end
        end
      end
    end
    n_tests++;
    if (q8.size() + q16.size() + q64.size() != 0) begin
      n_fail++;
      $display("FAIL sweep_drain: %0d/%0d/%0d results missing, want 0",
               q8.size(), q16.size(), q64.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sub();
    test_ovf();
    test_back_to_back_stall();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
